// File: rtl/fsk_link_pkg.sv
// Shared state types and elaboration-time helpers for the FSK frame link.
package fsk_link_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_CHECK, RX_DATA, RX_STOP} rx_state_t;

  // Edge spacing at or below this many cycles is classed as mark.
  function automatic int fsk_thresh(input int half0, input int half1);
    return (half0 + half1) / 2;
  endfunction

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsk_edge_demod.sv
// FSK demodulator: synchronises sig_rx, times the spacing between edges of
// either polarity and classifies each spacing as mark or space.
module fsk_edge_demod
  import fsk_link_pkg::*;
#(
  parameter int HALF0 = 8,
  parameter int HALF1 = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic sig_rx,
  output logic demod,
  output logic carrier
);

  localparam int SAT_VAL = 2 * HALF0 + 1;
  localparam int IW      = cnt_w(2 * HALF0 + 2);
  localparam logic [IW-1:0] SAT    = IW'(SAT_VAL);
  localparam logic [IW-1:0] SAT_M1 = IW'(SAT_VAL - 1);
  localparam logic [IW-1:0] THRESH = IW'(fsk_thresh(HALF0, HALF1));

  logic [2:0]    sync;
  logic          rx_edge;
  logic [IW-1:0] interval;

  // sync[1] is the metastability-hardened sample; sync[2] is its previous value.
  assign rx_edge = sync[2] ^ sync[1];

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync     <= '0;
      interval <= '0;
      demod    <= 1'b1;
      carrier  <= 1'b0;
    end else begin
      sync <= {sync[1:0], sig_rx};
      if (rx_edge) begin
        interval <= IW'(1);
        carrier  <= 1'b1;
        // First edge after silence has no meaningful spacing; keep reporting mark.
        demod    <= (interval == SAT) || (interval <= THRESH);
      end else if (interval != SAT) begin
        interval <= interval + IW'(1);
        if (interval == SAT_M1) begin
          carrier <= 1'b0;
          demod   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fsk_frame_link.sv
// FSK link endpoint: frames and tone-keys outgoing words onto sig_rf, and
// deframes words demodulated from sig_rx. All timing from sysclk counters.
module fsk_frame_link
  import fsk_link_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int BIT_DIV = 256,
  parameter int HALF0   = 8,
  parameter int HALF1   = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             sig_rf,
  input  logic             sig_rx,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic             carrier
);

  localparam int BW = cnt_w(BIT_DIV);
  localparam int XW = cnt_w(WIDTH);
  localparam int HW = cnt_w(HALF0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BIT_DIV / 2 - 1);
  localparam logic [XW-1:0] IDX_LAST  = XW'(WIDTH - 1);
  localparam logic [HW-1:0] H0_LAST   = HW'(HALF0 - 1);
  localparam logic [HW-1:0] H1_LAST   = HW'(HALF1 - 1);

  // ---------------- transmit framing ----------------
  tx_state_t        tx_state, tx_state_n;
  logic [BW-1:0]    tx_cnt;
  logic [XW-1:0]    tx_idx;
  logic [WIDTH-1:0] tx_shift;
  logic             tx_bit_end, tx_accept, tx_key;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  // Ready in the last stop cycle so a queued word follows with no idle gap.
  assign tx_ready   = (tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end);
  assign tx_accept  = tx_valid && tx_ready;

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    tx_state_n = tx_state;
    tx_key     = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_accept) tx_state_n = TX_START;
      TX_START: begin
        tx_key = 1'b0;
        if (tx_bit_end) tx_state_n = TX_DATA;
      end
      TX_DATA: begin
        tx_key = tx_shift[WIDTH-1];
        if (tx_bit_end && (tx_idx == IDX_LAST)) tx_state_n = TX_STOP;
      end
      TX_STOP:  if (tx_bit_end) tx_state_n = tx_accept ? TX_START : TX_IDLE;
      default:  tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_accept) begin
        tx_shift <= tx_data;
        tx_cnt   <= '0;
        tx_idx   <= '0;
      end else if (tx_state != TX_IDLE) begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + BW'(1);
        if ((tx_state == TX_DATA) && tx_bit_end) begin
          tx_shift <= tx_shift << 1;
          tx_idx   <= (tx_idx == IDX_LAST) ? '0 : tx_idx + XW'(1);
        end
      end
    end
  end

  // ---------------- phase-continuous tone generator ----------------
  // The keyed bit is only picked up at a toggle, so a half-period is never cut short.
  logic [HW-1:0] tone_cnt;
  logic          tone_mark;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tone_cnt  <= '0;
      tone_mark <= 1'b1;
      sig_rf    <= 1'b0;
    end else if (tone_cnt == (tone_mark ? H1_LAST : H0_LAST)) begin
      tone_cnt  <= '0;
      tone_mark <= tx_key;
      sig_rf    <= ~sig_rf;
    end else begin
      tone_cnt <= tone_cnt + HW'(1);
    end
  end

  // ---------------- receive deframing ----------------
  logic demod;

  fsk_edge_demod #(
    .HALF0 (HALF0),
    .HALF1 (HALF1)
  ) u_demod (
    .sysclk  (sysclk),
    .reset   (reset),
    .sig_rx  (sig_rx),
    .demod   (demod),
    .carrier (carrier)
  );

  rx_state_t        rx_state, rx_state_n;
  logic [BW-1:0]    rx_cnt;
  logic [XW-1:0]    rx_idx;
  logic [WIDTH-1:0] rx_shift;
  logic             rx_bit_end, valid_n, err_n;

  assign rx_bit_end = (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_n = rx_state;
    valid_n    = 1'b0;
    err_n      = 1'b0;
    case (rx_state)
      RX_IDLE: if (!demod) rx_state_n = RX_CHECK;
      RX_CHECK: begin
        if (!carrier) begin
          err_n      = 1'b1;
          rx_state_n = RX_IDLE;
        end else if (rx_cnt == HALF_LAST) begin
          rx_state_n = demod ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (!carrier) begin
          err_n      = 1'b1;
          rx_state_n = RX_IDLE;
        end else if (rx_bit_end && (rx_idx == IDX_LAST)) begin
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!carrier) begin
          err_n      = 1'b1;
          rx_state_n = RX_IDLE;
        end else if (rx_bit_end) begin
          valid_n    = demod;
          err_n      = !demod;
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
      if (rx_state_n != rx_state) begin
        rx_cnt <= '0;
      end else if (rx_state != RX_IDLE) begin
        rx_cnt <= rx_bit_end ? '0 : rx_cnt + BW'(1);
      end
      if (rx_state == RX_CHECK) begin
        rx_idx <= '0;
      end else if ((rx_state == RX_DATA) && rx_bit_end) begin
        rx_shift <= (rx_shift << 1) | WIDTH'(demod);
        rx_idx   <= rx_idx + XW'(1);
      end
      if (valid_n) rx_data <= rx_shift;
    end
  end

endmodule

// File: tb/tb_fsk_frame_link.sv
// Scoreboard bench for fsk_frame_link: directed frames over loopback and
// injected tones, with a monitor checking every rx_valid / rx_err pulse.
`timescale 1ns/1ps
module tb_fsk_frame_link;

  localparam int WIDTH   = 16;
  localparam int BIT_DIV = 256;
  localparam int HALF0   = 8;
  localparam int HALF1   = 4;
  localparam int FRAME   = (WIDTH + 2) * BIT_DIV;
  localparam int LIMIT   = FRAME + 1000;

  logic             sysclk   = 1'b0;
  logic             reset    = 1'b1;
  logic [WIDTH-1:0] tx_data  = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready, sig_rf, sig_rx;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid, rx_err, carrier;

  // sig_rx source: 0 = loopback of sig_rf, 1 = bench tone, 2 = constant level
  int   rx_mode  = 0;
  logic rx_const = 1'b0;
  logic gen      = 1'b0;
  int   gen_half = HALF1;
  int   gcnt     = 0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic             is_err;
    logic [WIDTH-1:0] data;
  } exp_t;
  exp_t             exp_q[$];
  logic [WIDTH-1:0] last_word = '0;

  fsk_frame_link #(
    .WIDTH   (WIDTH),
    .BIT_DIV (BIT_DIV),
    .HALF0   (HALF0),
    .HALF1   (HALF1)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .sig_rf   (sig_rf),
    .sig_rx   (sig_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .carrier  (carrier)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (gcnt >= gen_half - 1) begin
      gcnt <= 0;
      gen  <= ~gen;
    end else begin
      gcnt <= gcnt + 1;
    end
  end

  assign sig_rx = (rx_mode == 0) ? sig_rf : (rx_mode == 1) ? gen : rx_const;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_valid(input logic [WIDTH-1:0] w);
    exp_t e;
    e.is_err  = 1'b0;
    e.data    = w;
    last_word = w;
    exp_q.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_word;
    exp_q.push_back(e);
  endtask

  // Called at a negedge with tx_ready high; returns at the negedge after acceptance.
  task automatic send_word(input logic [WIDTH-1:0] w);
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge sysclk);
    tx_valid = 1'b0;
  endtask

  // n counts cycles from acceptance until tx_ready is seen high again.
  task automatic wait_ready(output int n);
    n = 1;
    while (!tx_ready && n < LIMIT) begin
      @(negedge sysclk);
      n++;
    end
  endtask

  // Monitor: every receive pulse is matched against the front of the scoreboard.
  always @(negedge sysclk) begin
    exp_t e;
    if (reset && (rx_valid || rx_err)) begin
      check("rx_pulse_exclusive", 32'(rx_valid & rx_err), 32'd0);
      if (exp_q.size() == 0) begin
        check("rx_unexpected_pulse", {30'd0, rx_valid, rx_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check(e.is_err ? "rx_err_pulse" : "rx_valid_pulse",
              {30'd0, rx_valid, rx_err}, e.is_err ? 32'd1 : 32'd2);
        check("rx_data", 32'(rx_data), 32'(e.data));
      end
    end
  end

  initial begin
    #(64'd2_000_000);
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic saw_low;

    #2 reset = 1'b0;
    repeat (3) @(negedge sysclk);
    check("reset_sig_rf",   32'(sig_rf),   32'd0);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_rx_data",  32'(rx_data),  32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_err",   32'(rx_err),   32'd0);
    check("reset_carrier",  32'(carrier),  32'd0);

    // Idle mark tone: toggles on every 4th clock after release.
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge sysclk);
      check("idle_tone", 32'(sig_rf), 32'((k / 4) % 2));
    end
    check("idle_tx_ready", 32'(tx_ready), 32'd1);
    repeat (50) @(negedge sysclk);
    check("idle_carrier", 32'(carrier), 32'd1);

    // Loopback single frame.
    expect_valid(16'hA53C);
    send_word(16'hA53C);
    check("tx_ready_drop", 32'(tx_ready), 32'd0);
    wait_ready(n);
    check("frame_busy_cycles", 32'(n), 32'(FRAME));
    repeat (300) @(negedge sysclk);

    // Back-to-back with tx_valid held high.
    expect_valid(16'h0001);
    expect_valid(16'hFFFF);
    tx_data  = 16'h0001;
    tx_valid = 1'b1;
    @(negedge sysclk);
    tx_data = 16'hFFFF;
    wait_ready(n);
    check("b2b_interval", 32'(n), 32'(FRAME));
    @(negedge sysclk);
    check("b2b_second_accepted", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_ready(n);
    check("b2b_frame2_cycles", 32'(n), 32'(FRAME));
    repeat (300) @(negedge sysclk);

    // Space tone injected across the stop bit of 16'h1234.
    expect_err();
    send_word(16'h1234);
    repeat ((WIDTH + 1) * BIT_DIV) @(negedge sysclk);
    gen_half = HALF0;
    rx_mode  = 1;
    repeat (200) @(negedge sysclk);
    rx_mode = 0;
    wait_ready(n);
    check("stopfault_tx_done", 32'(tx_ready), 32'd1);
    repeat (400) @(negedge sysclk);

    // Input frozen mid-frame: carrier lost, frame aborted.
    expect_err();
    send_word(16'h5A5A);
    repeat (2000) @(negedge sysclk);
    check("carrier_mid_frame", 32'(carrier), 32'd1);
    rx_const = sig_rf;
    rx_mode  = 2;
    saw_low  = 1'b0;
    repeat (24) begin
      @(negedge sysclk);
      if (!carrier) saw_low = 1'b1;
    end
    check("carrier_lost", 32'(saw_low), 32'd1);
    gen_half = HALF1;
    rx_mode  = 1;
    wait_ready(n);
    repeat (300) @(negedge sysclk);
    rx_mode = 0;
    repeat (100) @(negedge sysclk);

    // Short space burst: false start rejected silently.
    check("glitch_pre_idle", 32'(tx_ready), 32'd1);
    gen_half = HALF0;
    rx_mode  = 1;
    repeat (64) @(negedge sysclk);
    rx_mode = 0;
    repeat (400) @(negedge sysclk);
    check("glitch_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("glitch_carrier", 32'(carrier), 32'd1);

    // Reset asserted mid-transmission.
    send_word(16'h0F0F);
    repeat (1000) @(negedge sysclk);
    @(posedge sysclk);
    #2 reset = 1'b0;
    #1;
    check("midreset_tx_ready", 32'(tx_ready), 32'd1);
    check("midreset_sig_rf",   32'(sig_rf),   32'd0);
    check("midreset_rx_data",  32'(rx_data),  32'd0);
    check("midreset_carrier",  32'(carrier),  32'd0);
    last_word = '0;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    repeat (4) @(negedge sysclk);
    check("midreset_tone_resume", 32'(sig_rf), 32'd1);
    repeat (600) @(negedge sysclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_rx_data", 32'(rx_data), 32'(last_word));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
